// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
//   NUM_REQ     : number of requesters sharing the 4:1 mux
//   arb_state_t : arbiter FSM states
//   SEL_*       : mux select codes {s0,s1} per requester
//   onehot()    : requester index -> one-hot grant vector
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/output channel bundle for the round-robin mux arbiter.
//   req[3:0]      : per-requester request (bit0=a .. bit3=d)
//   a, b, c, d    : requester data buses
//   gnt[3:0]      : one-hot grant
//   s0, s1        : mux select (MSB, LSB)
//   y, y_vld      : registered shared output channel
//   lock[3:0]     : grant lock per requester (only with MUX_ARB_LOCK_EN)
// Modports: master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if #(
    parameter int unsigned DW = 2
);
    logic [3:0]    req;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [3:0]    gnt;
    logic          s0;
    logic          s1;
    logic [DW-1:0] y;
    logic          y_vld;
`ifdef MUX_ARB_LOCK_EN
    logic [3:0]    lock;

    modport master (output req, a, b, c, d, lock, input gnt, s0, s1, y, y_vld);
    modport slave  (input req, a, b, c, d, lock, output gnt, s0, s1, y, y_vld);
`else
    modport master (output req, a, b, c, d, input gnt, s0, s1, y, y_vld);
    modport slave  (input req, a, b, c, d, output gnt, s0, s1, y, y_vld);
`endif
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req & ~mask,
// searching upward from ptr with wrap-around.
//   i_req, i_mask : candidate requests and exclusion mask
//   i_ptr         : search start index
//   o_any_c       : at least one candidate exists
//   o_idx_c       : index of the chosen candidate
module rr_pick (
    input  logic [3:0] i_req,
    input  logic [3:0] i_mask,
    input  logic [1:0] i_ptr,
    output logic       o_any_c,
    output logic [1:0] o_idx_c
);
    logic [3:0] w_cand;

    assign w_cand = i_req & ~i_mask;

    // Walk offsets high to low so the nearest offset from ptr wins last.
    always_comb begin
        logic [1:0] v_j;
        v_j     = 2'd0;
        o_any_c = 1'b0;
        o_idx_c = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            v_j = 2'(i_ptr + 2'(k));
            if (w_cand[v_j]) begin
                o_any_c = 1'b1;
                o_idx_c = v_j;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux among four requesters, with a
// bounded grant length and a registered output channel.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : mux4_rr_arbiter_if.slave (req, a..d in; gnt, s0, s1, y, y_vld out)
// Optional: MUX_ARB_LOCK_EN adds bus.lock; a locked owner ignores hold expiry.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned DW       = 2,
    parameter int unsigned HOLD_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    mux4_rr_arbiter_if.slave   bus
);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

    arb_state_t    r_state, w_state_nxt;
    logic [1:0]    r_ptr, w_ptr_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic [3:0]    r_gnt, w_gnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [DW-1:0] r_y, w_y_nxt;
    logic          r_y_vld;

    logic          w_lock_o;
    logic          w_others;
    logic          w_hold_end;
    logic          w_release;
    logic [1:0]    w_pick_ptr;
    logic [3:0]    w_pick_mask;
    logic          w_any;
    logic [1:0]    w_idx;
    logic [DW-1:0] w_mux;

`ifdef MUX_ARB_LOCK_EN
    assign w_lock_o = bus.lock[r_sel];
`else
    assign w_lock_o = 1'b0;
`endif

    // Owner is always r_sel while BUSY.
    assign w_others   = |(bus.req & ~onehot(r_sel));
    assign w_hold_end = (r_cnt == HOLD_LAST);
    assign w_release  = !bus.req[r_sel] || (w_hold_end && !w_lock_o && w_others);

    // On release the search restarts just past the owner and skips it.
    assign w_pick_ptr  = (r_state == BUSY) ? 2'(r_sel + 2'd1) : r_ptr;
    assign w_pick_mask = (r_state == BUSY) ? onehot(r_sel) : 4'd0;

    rr_pick u_pick (
        .i_req   (bus.req),
        .i_mask  (w_pick_mask),
        .i_ptr   (w_pick_ptr),
        .o_any_c (w_any),
        .o_idx_c (w_idx)
    );

    // 4:1 data mux driven by the registered select.
    always_comb begin
        w_mux = bus.a;
        case (r_sel)
            SEL_A:   w_mux = bus.a;
            SEL_B:   w_mux = bus.b;
            SEL_C:   w_mux = bus.c;
            SEL_D:   w_mux = bus.d;
            default: w_mux = bus.a;
        endcase
    end

    // y only captures while an owner is being served, else holds.
    assign w_y_nxt = (r_state == BUSY) ? w_mux : r_y;

    // Next-state and grant control.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = onehot(w_idx);
                    w_sel_nxt   = w_idx;
                    w_cnt_nxt   = 4'd0;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_ptr_nxt = 2'(r_sel + 2'd1);
                    w_cnt_nxt = 4'd0;
                    if (w_any) begin
                        w_gnt_nxt = onehot(w_idx);
                        w_sel_nxt = w_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = 4'd0;
                    end
                end else if (w_hold_end) begin
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = 4'(r_cnt + 4'd1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= 2'd0;
            r_cnt   <= 4'd0;
            r_gnt   <= 4'd0;
            r_sel   <= 2'd0;
            r_y     <= '0;
            r_y_vld <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_y     <= w_y_nxt;
            r_y_vld <= (r_state == BUSY);
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.s0    = r_sel[1];
    assign bus.s1    = r_sel[0];
    assign bus.y     = r_y;
    assign bus.y_vld = r_y_vld;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_mux4_rr_arbiter;
    localparam int unsigned DW       = 2;
    localparam int unsigned HOLD_CYC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .HOLD_CYC(HOLD_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_busy;
    int            m_owner;
    int            m_ptr;
    int            m_cnt;
    int            m_sel;
    logic [DW-1:0] m_y;
    bit            m_yv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lock_of(input int idx);
`ifdef MUX_ARB_LOCK_EN
        return bus.lock[idx];
`else
        return (idx < 0);
`endif
    endfunction

    // One clock edge of the arbiter, described from the grant rules.
    task automatic model_edge();
        logic [DW-1:0] data [4];
        logic [3:0]    rq;
        bit            found;
        bit            others;
        bit            rel;
        int            cand;
        data = '{bus.a, bus.b, bus.c, bus.d};
        rq   = bus.req;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
            m_y = '0; m_yv = 0;
            return;
        end
        if (m_busy) m_y = data[m_owner];
        m_yv = m_busy;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < 4 && !found; k++) begin
                cand = (m_ptr + k) % 4;
                if (rq[cand]) begin
                    found = 1; m_owner = cand; m_sel = cand; m_cnt = 0; m_busy = 1;
                end
            end
        end else begin
            others = 0;
            for (int i = 0; i < 4; i++) if (i != m_owner && rq[i]) others = 1;
            rel = !rq[m_owner] ||
                  (m_cnt == HOLD_CYC - 1 && !lock_of(m_owner) && others);
            if (rel) begin
                m_ptr = (m_owner + 1) % 4;
                found = 0;
                for (int k = 0; k < 4 && !found; k++) begin
                    cand = (m_ptr + k) % 4;
                    if (rq[cand] && cand != m_owner) begin
                        found = 1; m_owner = cand; m_sel = cand; m_cnt = 0;
                    end
                end
                if (!found) begin
                    m_busy = 0; m_cnt = 0;
                end
            end else if (m_cnt == HOLD_CYC - 1) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic compare();
        check("gnt",   32'(bus.gnt), m_busy ? 32'(1 << m_owner) : 32'd0);
        check("sel",   32'({bus.s0, bus.s1}), 32'(m_sel));
        check("y_vld", 32'(bus.y_vld), 32'(m_yv));
        check("y",     32'(bus.y), 32'(m_y));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic set_lock(input logic [3:0] v);
`ifdef MUX_ARB_LOCK_EN
        bus.lock = v;
`else
        if (v != 4'd0) $display("note: lock ignored in this build");
`endif
    endtask

    initial begin
        logic [3:0] nreq;
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.a = 2'b00; bus.b = 2'b01; bus.c = 2'b10; bus.d = 2'b11;
        set_lock(4'd0);
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_sel = 0; m_y = '0; m_yv = 0;

        // Reset held with all requests asserted
        repeat (2) begin
            step();
            check("rst_gnt", 32'(bus.gnt), 32'd0);
            check("rst_yv",  32'(bus.y_vld), 32'd0);
        end

        // Single requester c, held beyond the hold limit
        rst = 1'b0; bus.req = 4'b0000;
        repeat (2) step();
        bus.req = 4'b0100;
        step();
        check("single_gnt", 32'(bus.gnt), 32'h4);
        check("single_sel", 32'({bus.s0, bus.s1}), 32'h2);
        step();
        check("single_y",  32'(bus.y), 32'h2);
        check("single_yv", 32'(bus.y_vld), 32'h1);
        repeat (8) step();
        check("single_hold", 32'(bus.gnt), 32'h4);

        // Sole owner drops: empty
        bus.req = 4'b0000;
        step();
        check("empty_gnt", 32'(bus.gnt), 32'h0);
        check("empty_yv1", 32'(bus.y_vld), 32'h1);
        step();
        check("empty_yv2", 32'(bus.y_vld), 32'h0);
        check("empty_yhold", 32'(bus.y), 32'h2);

        // Full contention from a fresh reset: a,b,c,d,a with 4 cycles each
        rst = 1'b1; step();
        rst = 1'b0; bus.req = 4'b1111;
        for (int i = 1; i <= 17; i++) begin
            step();
            check("contend_gnt", 32'(bus.gnt), 32'(1 << (((i - 1) / 4) % 4)));
        end

        // Mid-grant reset, next grant starts at a
        rst = 1'b1; step();
        check("midrst_gnt", 32'(bus.gnt), 32'h0);
        check("midrst_sel", 32'({bus.s0, bus.s1}), 32'h0);
        rst = 1'b0; bus.req = 4'b1111;
        step();
        check("midrst_next", 32'(bus.gnt), 32'h1);

        // Early release: b owns, drops after 2 cycles with d waiting
        bus.req = 4'b0010; step();
        check("early_b", 32'(bus.gnt), 32'h2);
        bus.req = 4'b1010; step();
        bus.req = 4'b1000; step();
        check("early_d", 32'(bus.gnt), 32'h8);
        bus.req = 4'b1001;
        repeat (4) step();
        check("after_d", 32'(bus.gnt), 32'h1);

`ifdef MUX_ARB_LOCK_EN
        // Locked owner a keeps the grant under full contention
        rst = 1'b1; step();
        rst = 1'b0; bus.req = 4'b1111; set_lock(4'b0001);
        for (int i = 0; i < 10; i++) begin
            step();
            check("lock_gnt", 32'(bus.gnt), 32'h1);
        end
        set_lock(4'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            nreq = bus.req;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) nreq[i] = ~nreq[i];
            bus.req = nreq;
            bus.a = DW'($urandom); bus.b = DW'($urandom);
            bus.c = DW'($urandom); bus.d = DW'($urandom);
            set_lock(($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
